// File: rtl/aes_round_sequencer.sv
// Iterative AES-128 round sequencer.
// Drives one shared combinational round datapath over NR rounds: performs the initial
// AddRoundKey on acceptance, then registers the datapath state/key output once per cycle
// and presents the final state as the cipher on a valid/ready output stream.
// Optional feature: define AES_ABORT_EN to add an abort input that drops the block in
// flight (ROUND or DONE) and returns to IDLE with all datapath registers cleared.
module aes_round_sequencer #(
    parameter int unsigned NR  = 10,
    parameter int unsigned RCW = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [0:127]     plain,
    input  logic [0:127]     key,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [0:127]     cipher,
    output logic             busy,
    output logic [0:127]     rnd_state,
    output logic [0:127]     rnd_key,
    output logic [RCW-1:0]   rnd_num,
    output logic             rnd_last,
    input  logic [0:127]     rnd_cipher,
    input  logic [0:127]     rnd_newkey
`ifdef AES_ABORT_EN
    ,
    input  logic             abort
`endif
);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StRound = 2'd1;
    localparam logic [1:0] StDone  = 2'd2;

    localparam logic [RCW-1:0] RndFirst = RCW'(1);
    localparam logic [RCW-1:0] RndFinal = RCW'(NR);

    logic [1:0]     state_q,     state_d;
    logic [0:127]   rnd_state_q, rnd_state_d;
    logic [0:127]   rnd_key_q,   rnd_key_d;
    logic [0:127]   cipher_q,    cipher_d;
    logic [RCW-1:0] rnd_num_q,   rnd_num_d;
    logic           out_valid_q, out_valid_d;
    logic           abort_req;

`ifdef AES_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    // Next-state logic: accept in IDLE, iterate rounds, hold the result until taken.
    always_comb begin
        state_d     = state_q;
        rnd_state_d = rnd_state_q;
        rnd_key_d   = rnd_key_q;
        cipher_d    = cipher_q;
        rnd_num_d   = rnd_num_q;
        out_valid_d = out_valid_q;

        case (state_q)
            StIdle: begin
                if (in_valid) begin
                    // Initial AddRoundKey is done here so the datapath only sees rounds 1..NR.
                    rnd_state_d = plain ^ key;
                    rnd_key_d   = key;
                    rnd_num_d   = RndFirst;
                    state_d     = StRound;
                end
            end
            StRound: begin
                rnd_state_d = rnd_cipher;
                rnd_key_d   = rnd_newkey;
                if (rnd_num_q < RndFinal) begin
                    rnd_num_d = rnd_num_q + RndFirst;
                end else begin
                    cipher_d    = rnd_cipher;
                    rnd_num_d   = '0;
                    out_valid_d = 1'b1;
                    state_d     = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: begin
                state_d     = StIdle;
                rnd_num_d   = '0;
                out_valid_d = 1'b0;
            end
        endcase

        // Abort wins over any handshake; the block is dropped without a trace.
        if (abort_req && (state_q != StIdle)) begin
            state_d     = StIdle;
            rnd_state_d = '0;
            rnd_key_d   = '0;
            cipher_d    = '0;
            rnd_num_d   = '0;
            out_valid_d = 1'b0;
        end
    end

    // State registers with asynchronous active-high reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            rnd_state_q <= '0;
            rnd_key_q   <= '0;
            cipher_q    <= '0;
            rnd_num_q   <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rnd_state_q <= rnd_state_d;
            rnd_key_q   <= rnd_key_d;
            cipher_q    <= cipher_d;
            rnd_num_q   <= rnd_num_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Outputs are decoded directly from registered state.
    always_comb begin
        in_ready  = (state_q == StIdle);
        busy      = (state_q != StIdle);
        out_valid = out_valid_q;
        cipher    = cipher_q;
        rnd_state = rnd_state_q;
        rnd_key   = rnd_key_q;
        rnd_num   = rnd_num_q;
        rnd_last  = (rnd_num_q == RndFinal);
    end

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Bench for aes_round_sequencer: a behavioural AES round (S-box computed from GF(2^8)
// inversion) stands in for the combinational datapath; ciphers are scoreboarded.
module tb_aes_round_sequencer;

    localparam int NR  = 10;
    localparam int RCW = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [0:127]   plain = '0;
    logic [0:127]   key = '0;
    logic           out_valid;
    logic           out_ready = 1'b1;
    logic [0:127]   cipher;
    logic           busy;
    logic [0:127]   rnd_state;
    logic [0:127]   rnd_key;
    logic [RCW-1:0] rnd_num;
    logic           rnd_last;
    logic [0:127]   rnd_cipher;
    logic [0:127]   rnd_newkey;
    logic           abort = 1'b0;

    int n_checks = 0;
    int n_err    = 0;

    logic [0:127] cur_exp = '0;
    logic [0:127] exp_q[$];
    time          acc_times[$];

    always #5 clk = ~clk;

    aes_round_sequencer #(.NR(NR), .RCW(RCW)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .plain      (plain),
        .key        (key),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .cipher     (cipher),
        .busy       (busy),
        .rnd_state  (rnd_state),
        .rnd_key    (rnd_key),
        .rnd_num    (rnd_num),
        .rnd_last   (rnd_last),
        .rnd_cipher (rnd_cipher),
        .rnd_newkey (rnd_newkey)
`ifdef AES_ABORT_EN
        ,
        .abort      (abort)
`endif
    );

    // ---------------- AES reference round ----------------
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r;
        logic [7:0] x;
        r = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) r = r ^ x;
            x = xtime(x);
        end
        return r;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] p;
        logic [7:0] inv;
        p   = x;
        inv = 8'h01;
        for (int i = 1; i < 8; i++) begin
            p   = gmul(p, p);
            inv = gmul(inv, p);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [0:127] key_next(input logic [0:127] k, input int r);
        logic [7:0]  rc;
        logic [31:0] t, w0, w1, w2, w3;
        rc = (r == 0) ? 8'h00 : 8'h01;
        for (int i = 1; i < r; i++) rc = xtime(rc);
        t  = {sbox(k[104 +: 8]) ^ rc, sbox(k[112 +: 8]), sbox(k[120 +: 8]), sbox(k[96 +: 8])};
        w0 = k[0 +: 32] ^ t;
        w1 = k[32 +: 32] ^ w0;
        w2 = k[64 +: 32] ^ w1;
        w3 = k[96 +: 32] ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    function automatic logic [0:127] aes_round(input logic [0:127] s, input logic last);
        logic [7:0]   b[16];
        logic [7:0]   sr[16];
        logic [7:0]   a0, a1, a2, a3;
        logic [0:127] o;
        for (int i = 0; i < 16; i++) b[i] = sbox(s[8*i +: 8]);
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) sr[r + 4*c] = b[r + 4*((c + r) % 4)];
        for (int c = 0; c < 4; c++) begin
            a0 = sr[4*c]; a1 = sr[4*c+1]; a2 = sr[4*c+2]; a3 = sr[4*c+3];
            if (last) o[32*c +: 32] = {a0, a1, a2, a3};
            else o[32*c +: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                                  a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                                  a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                                  xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
        end
        return o;
    endfunction

    function automatic logic [0:127] aes_encrypt(input logic [0:127] p, input logic [0:127] k);
        logic [0:127] s;
        logic [0:127] rk;
        s  = p ^ k;
        rk = k;
        for (int r = 1; r <= NR; r++) begin
            rk = key_next(rk, r);
            s  = aes_round(s, r == NR) ^ rk;
        end
        return s;
    endfunction

    // Combinational datapath stand-in.
    always_comb begin
        rnd_newkey = key_next(rnd_key, int'(rnd_num));
        rnd_cipher = aes_round(rnd_state, rnd_last) ^ rnd_newkey;
    end

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Scoreboard: push on accepted input, pop on delivered output (sampled mid-cycle).
    always @(negedge clk) begin
        if (!rst && in_valid && in_ready) begin
            exp_q.push_back(cur_exp);
            acc_times.push_back($time);
        end
        if (!rst && out_valid && out_ready && !abort) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL unexpected_output: got %h, expected no output", cipher);
            end else begin
                check("cipher", cipher, exp_q.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [0:127] p;
        logic [0:127] k;
        logic [0:127] e;
    } vec_t;

    vec_t vecs[4];

    // Offers a block and returns one cycle after the acceptance edge.
    task automatic send(input vec_t v);
        int n;
        plain    = v.p;
        key      = v.k;
        cur_exp  = v.e;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 40) begin
            step();
            n++;
        end
        if (!in_ready) begin
            check("accept_timeout", 1, 0);
            in_valid = 1'b0;
        end else begin
            step();
            in_valid = 1'b0;
        end
    endtask

    // Full block with round-sequence and latency checks; out_ready assumed high.
    task automatic run_block(input vec_t v);
        send(v);
        check("init_state", rnd_state, v.p ^ v.k);
        check("init_key", rnd_key, v.k);
        for (int r = 1; r <= NR; r++) begin
            check("rnd_num", rnd_num, r);
            check("rnd_last", rnd_last, r == NR);
            check("early_out_valid", out_valid, 0);
            step();
        end
        check("out_valid_t10", out_valid, 1);
        check("rnd_num_done", rnd_num, 0);
        check("in_ready_done", in_ready, 0);
        check("busy_done", busy, 1);
        step();
        check("in_ready_idle", in_ready, 1);
        check("out_valid_idle", out_valid, 0);
    endtask

    task automatic wait_rnd(input int target);
        int n;
        n = 0;
        while (rnd_num != RCW'(target) && n < 20) begin
            step();
            n++;
        end
        check("reach_rnd", rnd_num, target);
    endtask

    initial begin
        logic [0:127] rp;
        logic [0:127] rk;
        int seen;

        vecs[0] = '{128'h00112233445566778899aabbccddeeff, 128'h000102030405060708090a0b0c0d0e0f,
                    128'h69c4e0d86a7b0430d8cdb78070b4c55a};
        vecs[1] = '{128'h3243f6a8885a308d313198a2e0370734, 128'h2b7e151628aed2a6abf7158809cf4f3c,
                    128'h3925841d02dc09fbdc118597196a0b32};
        vecs[2] = '{128'h0, 128'h0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e};
        rp = {$urandom, $urandom, $urandom, $urandom};
        rk = {$urandom, $urandom, $urandom, $urandom};
        vecs[3] = '{rp, rk, aes_encrypt(rp, rk)};

        // Reset state
        step();
        check("rst_in_ready", in_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_cipher", cipher, 0);
        check("rst_rnd_state", rnd_state, 0);
        check("rst_rnd_key", rnd_key, 0);
        check("rst_rnd_num", rnd_num, 0);
        check("rst_rnd_last", rnd_last, 0);
        rst = 1'b0;
        step();

        foreach (vecs[i]) run_block(vecs[i]);

        // Backpressure: cipher held, source ignored while busy.
        out_ready = 1'b0;
        send(vecs[0]);
        repeat (NR) step();
        check("bp_out_valid", out_valid, 1);
        plain    = vecs[1].p;
        key      = vecs[1].k;
        cur_exp  = vecs[1].e;
        in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            check("bp_cipher_stable", cipher, vecs[0].e);
            check("bp_out_valid_hold", out_valid, 1);
            check("bp_in_ready", in_ready, 0);
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        check("bp_release_idle", in_ready, 1);
        check("bp_release_ov", out_valid, 0);

        // Back-to-back: second block held during ROUND, accepted 12 cycles later.
        acc_times.delete();
        send(vecs[1]);
        plain    = vecs[3].p;
        key      = vecs[3].k;
        cur_exp  = vecs[3].e;
        in_valid = 1'b1;
        send(vecs[3]);
        check("accept_count", acc_times.size(), 2);
        if (acc_times.size() == 2) check("accept_period", (acc_times[1] - acc_times[0]) / 10, 12);
        repeat (NR + 1) step();
        check("b2b_idle", in_ready, 1);

        // Asynchronous reset mid-block.
        send(vecs[1]);
        wait_rnd(5);
        rst = 1'b1;
        #1;
        check("arst_out_valid", out_valid, 0);
        check("arst_in_ready", in_ready, 1);
        check("arst_busy", busy, 0);
        check("arst_rnd_num", rnd_num, 0);
        check("arst_rnd_state", rnd_state, 0);
        check("arst_rnd_key", rnd_key, 0);
        check("arst_cipher", cipher, 0);
        exp_q.delete();
        step();
        rst = 1'b0;
        step();
        run_block(vecs[0]);

`ifdef AES_ABORT_EN
        // Abort in ROUND.
        send(vecs[1]);
        wait_rnd(3);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_rnd_num", rnd_num, 0);
        check("abort_rnd_state", rnd_state, 0);
        check("abort_rnd_key", rnd_key, 0);
        exp_q.delete();
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            if (out_valid) seen = 1;
            step();
        end
        check("abort_no_out_valid", seen, 0);

        // Abort in DONE beats the output handshake.
        out_ready = 1'b0;
        send(vecs[0]);
        repeat (NR) step();
        check("abort_done_ov", out_valid, 1);
        abort     = 1'b1;
        out_ready = 1'b1;
        step();
        abort = 1'b0;
        check("abort_done_drop_ov", out_valid, 0);
        check("abort_done_cipher", cipher, 0);
        check("abort_done_idle", in_ready, 1);
        exp_q.delete();

        // Abort in IDLE is ignored; same-cycle input accepted.
        abort = 1'b1;
        send(vecs[2]);
        abort = 1'b0;
        check("abort_idle_busy", busy, 1);
        repeat (NR) step();
        check("abort_idle_ov", out_valid, 1);
        step();
`else
        // Without abort the same runs complete and deliver.
        send(vecs[1]);
        wait_rnd(3);
        seen = 0;
        for (int i = 0; i < 15 && seen == 0; i++) begin
            if (out_valid) seen = 1;
            else step();
        end
        check("noabort_completes", seen, 1);
        step();
        out_ready = 1'b0;
        send(vecs[0]);
        repeat (NR) step();
        check("noabort_done_ov", out_valid, 1);
        out_ready = 1'b1;
        step();
        check("noabort_done_idle", in_ready, 1);
`endif

        repeat (3) step();
        check("scoreboard_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
